updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//  - Parametrised successor to the 4-bit ripple counter: a WIDTH-bit synchronous up/down counter, modulo MODULUS.
//  - Supports parallel load, count enable, and a wrap or saturate mode.
//  - Provides complementary outputs and terminal-count/wrap flags for cascading stages.
//  - Sits beside the flip-flop primitives; building block for dividers, timers and BCD digit chains.
// PARAMETERS
//  WIDTH      4    counter width in bits, >=1
//  MODULUS    16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//  RESET_VAL  0    value loaded by reset; < MODULUS
//  SATURATE   0    0: wrap at range ends; 1: hold at range ends
// PORTS
//  clk       in   1      rising-edge clock, single domain
//  reset     in   1      synchronous, active-high reset
//  en        in   1      count enable, sampled at clk rising edge
//  up_dn     in   1      1 = count up, 0 = count down
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value to load
//  count     out  WIDTH  registered count
//  count_n   out  WIDTH  registered bitwise complement of count (always == ~count)
//  tc        out  1      combinational terminal count, for cascading
//  wrap      out  1      registered one-cycle pulse after a wrap (SATURATE=0)
//  sat       out  1      registered level: last enabled step was blocked at a limit (SATURATE=1)
// BEHAVIOUR
//  - Priority at each rising edge: reset > load > en > hold.
//  - Reset:
//    - count=RESET_VAL, count_n=~RESET_VAL, wrap=0, sat=0.
//    - Reset asserted mid-count aborts the count; a pending wrap pulse is cleared.
//  - Load:
//    - count = (load_val >= MODULUS) ? MODULUS-1 : load_val.
//    - wrap=0, sat=0. load+en in the same cycle: the load wins and no step occurs.
//  - Enabled step (en=1, load=0):
//    - Up:   count <  MODULUS-1 -> count+1.
//    - Down: count >  0         -> count-1.
//    - Up at MODULUS-1:
//      - SATURATE=0: count = 0, wrap=1 for the next cycle.
//      - SATURATE=1: count holds, sat=1.
//    - Down at 0:
//      - SATURATE=0: count = MODULUS-1, wrap=1.
//      - SATURATE=1: count holds, sat=1.
//  - Flag lifetimes:
//    - wrap is high for exactly one cycle per wrap event.
//    - sat clears on the first enabled step that moves count, or on load/reset. It holds while en=0.
//  - en=0: count, count_n and sat hold; wrap=0.
//  - Latency: one cycle from input sample to new count. No combinational path from inputs to count.
//  - tc = en & (up_dn ? count==MODULUS-1 : count==0).
//    - tc drives the en of the next cascaded stage in the same cycle.
//  - Arithmetic: compare against MODULUS-1 held in a WIDTH-bit constant.
//    - No intermediate overflow when MODULUS==2**WIDTH; the natural wrap must match the modulo result.
//  - Direction changes take effect on the same edge; no dead cycle.
//  - Parameter violations (MODULUS range, RESET_VAL >= MODULUS) raise an elaboration-time $error.
// STRUCTURE
//  - Package counter_pkg:
//    - typedef enum logic {CNT_DOWN=1'b0, CNT_UP=1'b1} cnt_dir_e.
//    - localparam function clog2-safe max helper.
//  - Sub-module dff_vec_sync_rst #(WIDTH, RESET_VAL):
//    - clk, reset, d, q, qn.
//    - Holds count / count_n; replaces per-bit flip-flop instances.
//  - Next-state logic and flags live in the top module. No FSM beyond the count register.
// TESTING  (WIDTH=4, MODULUS=10 unless noted)
//  1. reset=1 for 2 cycles with en=1 -> count=0, count_n=4'hF, wrap=0, sat=0; no step while reset held.
//  2. up_dn=1, en=1 for 12 cycles from 0 ->
//     - count 1..9, then 0, 1, 2; wrap=1 only in the cycle count=0 appears.
//     - tc=1 while count=9.
//  3. up_dn=0 from 0, one enabled step -> count=9, wrap=1; next step -> 8, wrap=0.
//  4. SATURATE=1: load 4'd15 -> count=9 (clipped).
//     - Then up steps hold at 9 with sat=1.
//     - One down step -> 8, sat=0.
//  5. load=1, load_val=5, en=1 same cycle -> count=5, no step. Then reset asserted at count=7 -> count=0 next edge.
//  6. MODULUS=16 (full range): up from 15 -> 0 with wrap=1; down from 0 -> 15. count_n==~count every cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the parametrised up/down counter family.
package counter_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  // Usable in localparam expressions; avoids relying on $clog2 of zero-width corners.
  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dff_vec_sync_rst.sv
// WIDTH-bit register with synchronous active-high reset and a registered complement output.
module dff_vec_sync_rst #(
  parameter int unsigned          WIDTH     = 4,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] qn_q;

  // Complement is its own flop so qn is glitch-free and never waits on an inverter after q.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q  <= RESET_VAL;
      qn_q <= ~RESET_VAL;
    end else begin
      q_q  <= d;
      qn_q <= ~d;
    end
  end

  assign q  = q_q;
  assign qn = qn_q;

endmodule

// File: rtl/updown_counter_param.sv
// WIDTH-bit synchronous up/down counter modulo MODULUS with load, enable,
// wrap/saturate mode, terminal count for cascading, and wrap/sat flags.
module updown_counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic             tc,
  output logic             wrap,
  output logic             sat
);

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be >= 1");
  end
  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
    $error("updown_counter_param: RESET_VAL must be < MODULUS");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable in the load clip compare.
  localparam int unsigned      CMP_W = umax(WIDTH, $clog2(MODULUS)) + 1;
  localparam logic [WIDTH-1:0] TOP_C = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
  localparam logic [CMP_W-1:0] MOD_C = CMP_W'(MODULUS);

  cnt_dir_e         dir;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_nq;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_clip;
  logic             at_top;
  logic             at_bot;
  logic             wrap_q;
  logic             wrap_d;
  logic             sat_q;
  logic             sat_d;

  assign dir       = cnt_dir_e'(up_dn);
  assign at_top    = (count_q == TOP_C);
  assign at_bot    = (count_q == '0);
  assign load_clip = (CMP_W'(load_val) >= MOD_C) ? TOP_C : load_val;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (load) begin
      count_d = load_clip;
      sat_d   = 1'b0;
    end else if (en) begin
      if (dir == CNT_UP) begin
        if (!at_top) begin
          count_d = count_q + WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          sat_d   = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_bot) begin
          count_d = count_q - WIDTH'(1);
          sat_d   = 1'b0;
        end else if (SATURATE) begin
          sat_d   = 1'b1;
        end else begin
          count_d = TOP_C;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  dff_vec_sync_rst #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RST_C)
  ) u_count_reg (
    .clk  (clk),
    .reset(reset),
    .d    (count_d),
    .q    (count_q),
    .qn   (count_nq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign count   = count_q;
  assign count_n = count_nq;
  assign wrap    = wrap_q;
  assign sat     = sat_q;
  assign tc      = en & ((dir == CNT_UP) ? at_top : at_bot);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench: three counter configurations share stimulus and are compared to a behavioural model.
module tb_updown_counter_param;

  logic clk;
  logic reset, en, up_dn, load;
  logic [3:0] load_val;

  // Instance 0: MODULUS=10 wrap, 1: MODULUS=10 saturate, 2: MODULUS=16 wrap.
  logic [2:0][3:0] cnt_a, cntn_a;
  logic [2:0]      tc_a, wrap_a, sat_a;

  int checks = 0;
  int errors = 0;

  int unsigned MODS [3] = '{10, 10, 16};
  bit          SATS [3] = '{1'b0, 1'b1, 1'b0};
  int          m_cnt  [3];
  bit          m_wrap [3];
  bit          m_sat  [3];

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_a[0]), .count_n(cntn_a[0]), .tc(tc_a[0]), .wrap(wrap_a[0]), .sat(sat_a[0]));

  updown_counter_param #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_a[1]), .count_n(cntn_a[1]), .tc(tc_a[1]), .wrap(wrap_a[1]), .sat(sat_a[1]));

  updown_counter_param #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0), .SATURATE(1'b0)) dut_full (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
    .count(cnt_a[2]), .count_n(cntn_a[2]), .tc(tc_a[2]), .wrap(wrap_a[2]), .sat(sat_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: move by +/-1 on the integer line; leaving [0, MOD-1] either wraps modulo MOD or is refused.
  function automatic void model_edge();
    for (int k = 0; k < 3; k++) begin
      int tgt;
      if (reset) begin
        m_cnt[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
      end else if (load) begin
        m_cnt[k]  = (int'(load_val) >= int'(MODS[k])) ? int'(MODS[k]) - 1 : int'(load_val);
        m_wrap[k] = 0; m_sat[k] = 0;
      end else if (en) begin
        tgt = m_cnt[k] + (up_dn ? 1 : -1);
        m_wrap[k] = 0;
        if (tgt >= 0 && tgt < int'(MODS[k])) begin
          m_cnt[k] = tgt; m_sat[k] = 0;
        end else if (SATS[k]) begin
          m_sat[k] = 1;
        end else begin
          m_cnt[k] = (tgt + int'(MODS[k])) % int'(MODS[k]);
          m_wrap[k] = 1;
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  endfunction

  function automatic logic [9:0] exp_vec(input int k);
    logic [3:0] c;
    c = 4'(m_cnt[k]);
    return {c, ~c, m_wrap[k], m_sat[k]};
  endfunction

  function automatic logic [9:0] obs_vec(input int k);
    return {cnt_a[k], cntn_a[k], wrap_a[k], sat_a[k]};
  endfunction

  function automatic logic exp_tc(input int k);
    return en && (up_dn ? (m_cnt[k] == int'(MODS[k]) - 1) : (m_cnt[k] == 0));
  endfunction

  task automatic drive(input logic r, input logic l, input logic [3:0] lv, input logic e, input logic ud);
    reset = r; load = l; load_val = lv; en = e; up_dn = ud;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 4'd0, 1, 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== 10'b0000_1111_0_0) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d {cnt,cnt_n,wrap,sat}=%b required %b", k, c, obs_vec(k), 10'b0000_1111_0_0);
        end
      end
    end
  endtask

  task automatic test_count_up();
    drive(0, 0, 4'd0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tc_a[k] !== exp_tc(k)) begin
          errors++;
          $display("FAIL up_tc inst%0d step%0d tc=%b required %b", k, i, tc_a[k], exp_tc(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL up_count inst%0d step%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (cnt_a[0] !== 4'((i + 1) % 10) || wrap_a[0] !== (i == 9)) begin
        errors++;
        $display("FAIL up_seq step%0d count=%0d wrap=%b required %0d/%b", i, cnt_a[0], wrap_a[0], (i + 1) % 10, (i == 9));
      end
    end
  endtask

  task automatic test_count_down();
    drive(1, 0, 4'd0, 0, 0);
    tick();
    drive(0, 0, 4'd0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (tc_a[0] !== (i == 0)) begin
        errors++;
        $display("FAIL down_tc step%0d tc=%b required %b", i, tc_a[0], (i == 0));
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL down inst%0d step%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (cnt_a[0] !== ((i == 0) ? 4'd9 : 4'd8) || wrap_a[0] !== (i == 0)) begin
        errors++;
        $display("FAIL down_seq step%0d count=%0d wrap=%b required %0d/%b", i, cnt_a[0], wrap_a[0], (i == 0) ? 9 : 8, (i == 0));
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] want_c [6] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd8};
    logic       want_s [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       drive(0, 1, 4'd15, 0, 1);
        1, 2, 3: drive(0, 0, 4'd0, 1, 1);
        4:       drive(0, 0, 4'd0, 0, 0);
        default: drive(0, 0, 4'd0, 1, 0);
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL saturate inst%0d step%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (cnt_a[1] !== want_c[i] || sat_a[1] !== want_s[i]) begin
        errors++;
        $display("FAIL sat_seq step%0d count=%0d sat=%b required %0d/%b", i, cnt_a[1], sat_a[1], want_c[i], want_s[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    logic [3:0] want [4] = '{4'd5, 4'd6, 4'd7, 4'd0};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(0, 1, 4'd5, 1, 1);
        1, 2:    drive(0, 0, 4'd0, 1, 1);
        default: drive(1, 0, 4'd0, 1, 1);
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL load_prio inst%0d step%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (cnt_a[0] !== want[i]) begin
        errors++;
        $display("FAIL load_seq step%0d count=%0d required %0d", i, cnt_a[0], want[i]);
      end
    end
  endtask

  task automatic test_full_range();
    logic [3:0] want [3] = '{4'd15, 4'd0, 4'd15};
    logic       wwr  [3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(0, 1, 4'd15, 0, 1);
        1:       drive(0, 0, 4'd0, 1, 1);
        default: drive(0, 0, 4'd0, 1, 0);
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL full_range inst%0d step%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
      checks++;
      if (cnt_a[2] !== want[i] || wrap_a[2] !== wwr[i] || cntn_a[2] !== ~want[i]) begin
        errors++;
        $display("FAIL full_seq step%0d count=%0d n=%0d wrap=%b required %0d/%0d/%b",
                 i, cnt_a[2], cntn_a[2], wrap_a[2], want[i], ~want[i], wwr[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tc_a[k] !== exp_tc(k)) begin
          errors++;
          $display("FAIL rand_tc inst%0d cyc%0d tc=%b required %b", k, i, tc_a[k], exp_tc(k));
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs_vec(k) !== exp_vec(k)) begin
          errors++;
          $display("FAIL rand inst%0d cyc%0d got %b required %b", k, i, obs_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
    end
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_priority();
    test_full_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
